// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared constants and hazard FSM state type for the RV32I pipeline
package pipeline_pkg;

  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    TIMEOUT  = 2'd2
  } hazard_state_t;

endpackage

// File: rtl/hazard_perf_counter.sv
// rtl/hazard_perf_counter.sv - saturating event counter with synchronous active-high reset
module hazard_perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Holds at all-ones so a long stall storm never reads back as a small count.
  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/stall_flush_ctrl.sv
// rtl/stall_flush_ctrl.sv - load-use / redirect / memory-wait stall and flush controller
// Optional saturating perf counters enabled by defining STALL_PERF_CNT_EN.
module stall_flush_ctrl
  import pipeline_pkg::*;
#(
  parameter int REG_ADDR_W  = pipeline_pkg::REG_ADDR_W,
  parameter int MEM_TIMEOUT = 255
`ifdef STALL_PERF_CNT_EN
  ,
  parameter int CNT_W       = 32
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] source_reg1_id,
  input  logic [REG_ADDR_W-1:0] source_reg2_id,
  input  logic [REG_ADDR_W-1:0] reg_dest_ex,
  input  logic                  mem_read_ex,
  input  logic                  pc_src_ex,
  input  logic                  dmem_req_mem,
  input  logic                  dmem_ready,
  output logic                  stall_f,
  output logic                  stall_d,
  output logic                  stall_e,
  output logic                  stall_m,
  output logic                  flush_d,
  output logic                  flush_e,
  output logic                  flush_w,
  output logic                  mem_timeout
`ifdef STALL_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      flush_count
`endif
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  hazard_state_t     state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              mem_timeout_q, mem_timeout_d;

  logic lw_stall;
  logic mem_stall;
  logic halt;

  assign lw_stall  = mem_read_ex && (reg_dest_ex != '0) &&
                     ((reg_dest_ex == source_reg1_id) || (reg_dest_ex == source_reg2_id));
  assign mem_stall = dmem_req_mem && !dmem_ready;
  assign halt      = (state_q == TIMEOUT);

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;
    unique case (state_q)
      RUN: begin
        if (mem_stall) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = WAIT_W'(1);
        end else begin
          wait_cnt_d = '0;
        end
      end
      MEM_WAIT: begin
        if (dmem_ready || !dmem_req_mem) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d       = TIMEOUT;
          mem_timeout_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      TIMEOUT: begin
        state_d = TIMEOUT;
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= RUN;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  // A frozen EX keeps pc_src_ex asserted, so suppressing flushes during a memory wait loses no redirect.
  always_comb begin
    stall_f = halt || mem_stall || lw_stall;
    stall_d = halt || mem_stall || lw_stall;
    stall_e = halt || mem_stall;
    stall_m = halt || mem_stall;
    flush_w = halt || mem_stall;
    flush_d = !halt && !mem_stall && pc_src_ex;
    flush_e = !halt && !mem_stall && (lw_stall || pc_src_ex);
    if (reset) begin
      stall_f = 1'b0;
      stall_d = 1'b0;
      stall_e = 1'b0;
      stall_m = 1'b0;
      flush_d = 1'b1;
      flush_e = 1'b1;
      flush_w = 1'b1;
    end
  end

  assign mem_timeout = mem_timeout_q;

`ifdef STALL_PERF_CNT_EN
  hazard_perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (stall_f),
    .count_o (stall_cycles)
  );

  hazard_perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (flush_e),
    .count_o (flush_count)
  );
`endif

endmodule
